// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC and drives a single-outstanding
// req/valid instruction-memory handshake. A one-entry hold buffer keeps a returned word across stalls.
module fetch_stage #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
    parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR     = '0
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic                      i_StallF,
    input  logic                      i_PCSrcD,
    input  logic [ADDRESS_WIDTH-1:0]  i_PCBranchD,
    output logic                      o_IMemReq,
    output logic [ADDRESS_WIDTH-1:0]  o_IMemAddr,
    input  logic                      i_IMemValid,
    input  logic [INSTR_WIDTH-1:0]    i_IMemRData,
    output logic [INSTR_WIDTH-1:0]    o_InstrF,
    output logic                      o_InstrValidF,
    output logic                      o_FetchBusy,
    output logic [ADDRESS_WIDTH-1:0]  o_PCF,
    output logic [ADDRESS_WIDTH-1:0]  o_PCPlus4F
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HELD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]               state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] pc_reg, pc_next;
    logic [ADDRESS_WIDTH-1:0] drain_reg, drain_next;
    logic [INSTR_WIDTH-1:0]   hold_reg, hold_next;
    logic [ADDRESS_WIDTH-1:0] target;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     redirect;

    // Targets are always word aligned; the low two bits from decode are discarded.
    assign target   = i_PCBranchD & ~ADDRESS_WIDTH'(3);
    assign pc_plus4 = pc_reg + ADDRESS_WIDTH'(4);
    assign redirect = i_PCSrcD & ~i_StallF;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drain_next = drain_reg;
        hold_next  = hold_reg;
        case (state_reg)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (i_StallF) begin
                    if (i_IMemValid) begin
                        hold_next  = i_IMemRData;
                        state_next = S_HELD;
                    end
                end else if (i_PCSrcD) begin
                    pc_next = target;
                    if (!i_IMemValid) begin
                        // The in-flight read must complete before a new address may be issued.
                        drain_next = pc_reg;
                        state_next = S_DRAIN;
                    end
                end else if (i_IMemValid) begin
                    pc_next = pc_plus4;
                end
            end
            S_HELD: begin
                if (!i_StallF) begin
                    pc_next    = i_PCSrcD ? target : pc_plus4;
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect)
                    pc_next = target;
                if (i_IMemValid)
                    state_next = S_REQ;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_PC;
            drain_reg <= '0;
            hold_reg  <= NOP_INSTR;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            drain_reg <= drain_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        o_IMemReq     = 1'b0;
        o_IMemAddr    = pc_reg;
        o_InstrValidF = 1'b0;
        o_InstrF      = NOP_INSTR;
        case (state_reg)
            S_REQ: begin
                o_IMemReq     = 1'b1;
                o_InstrValidF = i_IMemValid;
                if (i_IMemValid)
                    o_InstrF = i_IMemRData;
            end
            S_HELD: begin
                o_InstrValidF = 1'b1;
                o_InstrF      = hold_reg;
            end
            S_DRAIN: begin
                o_IMemReq  = 1'b1;
                o_IMemAddr = drain_reg;
            end
            default: ;
        endcase
    end

    assign o_FetchBusy = ~o_InstrValidF;
    assign o_PCF       = pc_reg;
    assign o_PCPlus4F  = pc_plus4;

endmodule
